// File: rtl/sync_bits_debounce_pkg.sv
// Shared helpers for the sync_bits_debounce input conditioner.
package sync_bits_debounce_pkg;

    localparam int unsigned MIN_STAGES = 2;
    localparam int unsigned MAX_STAGES = 8;

    // Ceiling log2 via a bounded loop so it elaborates as a constant function.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

    // Debounce counter width: clog2(cycles+1), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_bits_debounce_chan.sv
// One channel: synchronizer chain, debounce counter, clean level and edge pulses.
module sync_bits_debounce_chan
    import sync_bits_debounce_pkg::*;
#(
    parameter int unsigned STAGES          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    input  logic i_filter_en,
    output logic o_dst,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW             = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned LAST           = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST     = CW'(LAST);
    localparam bit          FILTER_PRESENT = (DEBOUNCE_CYCLES > 0);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] r_sync;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_dst;
    logic          w_dst_nxt;
    logic          w_s;
    logic          w_filter_on;
    logic          r_rise;
    logic          r_fall;

    // Metastability chain; index 0 samples the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign w_s         = r_sync[STAGES-1];
    assign w_filter_on = i_filter_en && FILTER_PRESENT;

    // dst follows s only after s has differed for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        w_dst_nxt = r_dst;
        w_cnt_nxt = '0;
        if (!w_filter_on) begin
            w_dst_nxt = w_s;
        end else if (w_s != r_dst) begin
            if (r_cnt == CNT_LAST) begin
                w_dst_nxt = w_s;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst  <= RESET_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_dst  <= w_dst_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_dst_nxt & ~r_dst;
            r_fall <= ~w_dst_nxt & r_dst;
        end
    end

    assign o_dst  = r_dst;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/sync_bits_debounce.sv
// Multi-channel asynchronous level conditioner: sync chain, optional debounce, edge pulses.
module sync_bits_debounce
    import sync_bits_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      STAGES          = 3,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filter_en,
    output logic [WIDTH-1:0] dst,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("sync_bits_debounce: STAGES must be within 2..8");
    end

    // Channels are independent; no coherency across bits is implied.
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        sync_bits_debounce_chan #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[g])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_async     (async_in[g]),
            .i_filter_en (filter_en),
            .o_dst       (dst[g]),
            .o_rise      (rise[g]),
            .o_fall      (fall[g])
        );
    end

endmodule

// File: tb/tb_sync_bits_debounce.sv
// Directed per-cycle vector tables for a 4-channel filtered instance and a 1-channel bypass instance.
module tb_sync_bits_debounce;

    typedef struct packed {
        logic       rst;
        logic       fen;
        logic [3:0] ain;
        logic [3:0] dst;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst;
    logic       a_fen;
    logic [3:0] a_ain;
    logic [3:0] a_dst;
    logic [3:0] a_rise;
    logic [3:0] a_fall;

    logic       b_rst;
    logic       b_fen;
    logic [0:0] b_ain;
    logic [0:0] b_dst;
    logic [0:0] b_rise;
    logic [0:0] b_fall;

    sync_bits_debounce #(
        .WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0010)
    ) dut_a (
        .clk(clk), .rst(a_rst), .async_in(a_ain), .filter_en(a_fen),
        .dst(a_dst), .rise(a_rise), .fall(a_fall)
    );

    sync_bits_debounce #(
        .WIDTH(1), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0)
    ) dut_b (
        .clk(clk), .rst(b_rst), .async_in(b_ain), .filter_en(b_fen),
        .dst(b_dst), .rise(b_rise), .fall(b_fall)
    );

    int n_cmp = 0;
    int n_err = 0;

    vec_t q_a[$];
    vec_t q_b[$];

    function automatic vec_t mk(logic rst, logic fen, logic [3:0] ain,
                                logic [3:0] dst, logic [3:0] rise, logic [3:0] fall);
        vec_t v;
        v.rst = rst; v.fen = fen; v.ain = ain;
        v.dst = dst; v.rise = rise; v.fall = fall;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    initial begin
        logic [3:0] ain;

        // ---------------- table for instance A (STAGES=3, DEBOUNCE=4, RESET_VAL=0010)
        for (int e = 0; e < 3; e++) q_a.push_back(mk(1, 1, 4'b0001, 4'b0010, 4'b0000, 4'b0000));
        // release: dst reaches input at edge 3+4-1 = 6, rise[0] and fall[1]
        for (int e = 0; e < 8; e++)
            q_a.push_back(mk(0, 1, 4'b0001, (e < 6) ? 4'b0010 : 4'b0001,
                             (e == 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0010 : 4'b0000));
        // independence: ch0 steps 1->0, ch2 toggles every 2 cycles and never settles
        for (int e = 0; e < 10; e++) begin
            ain = 4'b0000;
            ain[2] = ((e / 2) % 2 == 0);
            q_a.push_back(mk(0, 1, ain, (e < 6) ? 4'b0001 : 4'b0000,
                             4'b0000, (e == 6) ? 4'b0001 : 4'b0000));
        end
        // latency: ch0 0->1, dst and rise exactly at edge 6, rise gone at edge 7
        for (int e = 0; e < 8; e++)
            q_a.push_back(mk(0, 1, 4'b0001, (e < 6) ? 4'b0000 : 4'b0001,
                             (e == 6) ? 4'b0001 : 4'b0000, 4'b0000));
        // glitch: 3-cycle high on ch1 never reaches dst
        for (int e = 0; e < 10; e++)
            q_a.push_back(mk(0, 1, (e < 3) ? 4'b0011 : 4'b0001, 4'b0001, 4'b0000, 4'b0000));
        // reset in the cycle ch3 count is at its last value
        for (int e = 0; e < 6; e++) q_a.push_back(mk(0, 1, 4'b1001, 4'b0001, 4'b0000, 4'b0000));
        q_a.push_back(mk(1, 1, 4'b1001, 4'b0010, 4'b0000, 4'b0000));
        for (int e = 0; e < 8; e++)
            q_a.push_back(mk(0, 1, 4'b1001, (e < 6) ? 4'b0010 : 4'b1001,
                             (e == 6) ? 4'b1001 : 4'b0000, (e == 6) ? 4'b0010 : 4'b0000));

        // ---------------- table for instance B (STAGES=2, DEBOUNCE=4), bit 0 only
        q_b.push_back(mk(1, 0, 4'b0, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(1, 0, 4'b0, 4'b0, 4'b0, 4'b0));
        // bypass: 1-cycle pulse -> dst high one cycle at edge 2, rise then fall
        q_b.push_back(mk(0, 0, 4'b1, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 0, 4'b0, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 0, 4'b0, 4'b1, 4'b1, 4'b0));
        q_b.push_back(mk(0, 0, 4'b0, 4'b0, 4'b0, 4'b1));
        q_b.push_back(mk(0, 0, 4'b0, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 0, 4'b0, 4'b0, 4'b0, 4'b0));
        // filter on, count reaches 2, then filter dropped -> dst updates next edge
        q_b.push_back(mk(0, 1, 4'b1, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 1, 4'b1, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 1, 4'b1, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 1, 4'b1, 4'b0, 4'b0, 4'b0));
        q_b.push_back(mk(0, 0, 4'b1, 4'b1, 4'b1, 4'b0));
        q_b.push_back(mk(0, 0, 4'b1, 4'b1, 4'b0, 4'b0));
        // filter re-enabled: count restarts, fall at edge 2+4-1 = 5
        for (int e = 0; e < 7; e++)
            q_b.push_back(mk(0, 1, 4'b0, (e < 5) ? 4'b1 : 4'b0, 4'b0, (e == 5) ? 4'b1 : 4'b0));

        a_rst = 1'b1; a_fen = 1'b1; a_ain = 4'b0001;
        b_rst = 1'b1; b_fen = 1'b0; b_ain = 1'b0;

        foreach (q_a[i]) begin
            a_rst = q_a[i].rst;
            a_fen = q_a[i].fen;
            a_ain = q_a[i].ain;
            @(posedge clk);
            #1;
            chk("A.dst",  i, a_dst,  q_a[i].dst);
            chk("A.rise", i, a_rise, q_a[i].rise);
            chk("A.fall", i, a_fall, q_a[i].fall);
        end

        foreach (q_b[i]) begin
            b_rst = q_b[i].rst;
            b_fen = q_b[i].fen;
            b_ain = q_b[i].ain[0:0];
            @(posedge clk);
            #1;
            chk("B.dst",  i, {3'b000, b_dst},  q_b[i].dst);
            chk("B.rise", i, {3'b000, b_rise}, q_b[i].rise);
            chk("B.fall", i, {3'b000, b_fall}, q_b[i].fall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
